// File: rtl/prime_factor_seq.sv
// prime_factor_seq: trial-division factoriser by primes 2..23 with a wrapping factor-index display sequencer
module prime_factor_seq (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       START,
  input  logic [7:0] NIN,
  input  logic       NEXT,
  output logic [3:0] DOUT,
  output logic [3:0] COUNT,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVF
);
  typedef enum logic [1:0] {IDLE, DIV, CHECK, FIN} state_t;
  state_t state, state_nx;
  logic [7:0] n, r, q, p;
  logic [3:0] pi, wp;
  logic [2:0] rp;
  logic [3:0] fbuf [0:7];
  logic go, ge, last;
  assign go   = START && (state == IDLE || state == FIN);
  assign ge   = r >= p;
  assign last = pi == 4'd9;
  always_comb begin
    p = 8'd2;
    case (pi)
      4'd2:    p = 8'd3;
      4'd3:    p = 8'd5;
      4'd4:    p = 8'd7;
      4'd5:    p = 8'd11;
      4'd6:    p = 8'd13;
      4'd7:    p = 8'd17;
      4'd8:    p = 8'd19;
      4'd9:    p = 8'd23;
      default: p = 8'd2;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FIN: if (go) state_nx = NIN < 8'd2 ? FIN : DIV;
      DIV:       if (!ge) state_nx = CHECK;
      CHECK:     state_nx = r == 8'd0 ? (q == 8'd1 ? FIN : DIV) : (last ? FIN : DIV);
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      n   <= 8'd0;
      r   <= 8'd0;
      q   <= 8'd0;
      pi  <= 4'd1;
      wp  <= 4'd0;
      rp  <= 3'd0;
      OVF <= 1'b0;
    end else if (go) begin
      n   <= NIN;
      r   <= NIN;
      q   <= 8'd0;
      pi  <= 4'd1;
      wp  <= 4'd0;
      rp  <= 3'd0;
      OVF <= 1'b0;
    end else begin
      case (state)
        DIV: if (ge) begin
          r <= r - p;
          q <= q + 8'd1;
        end
        CHECK: if (r == 8'd0) begin
          wp <= wp + 4'd1;
          n  <= q;
          r  <= q;
          q  <= 8'd0;
        end else begin
          r <= n;
          q <= 8'd0;
          if (!last) pi <= pi + 4'd1;
          else begin
            wp  <= wp + 4'd1;
            OVF <= 1'b1;
          end
        end
        FIN: if (NEXT && wp != 4'd0) rp <= {1'b0, rp} == wp - 4'd1 ? 3'd0 : rp + 3'd1;
        default: ;
      endcase
    end
  // A residual prime above 23 is recorded as index 0 (dash)
  always_ff @(posedge CLK)
    if (state == CHECK && (r == 8'd0 || last)) fbuf[wp[2:0]] <= r == 8'd0 ? pi : 4'd0;
  assign BUSY  = state == DIV || state == CHECK;
  assign DONE  = state == FIN;
  assign COUNT = wp;
  assign DOUT  = (DONE && wp != 4'd0) ? fbuf[rp] : 4'd0;
endmodule
